cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control unit that sequences the existing IMem, IDecode, RegisterFile and ALU datapath through fetch, decode, execute, memory and writeback.
- Owns the program counter and the per-stage enables (idctrl, regctrl, dmctrl-class strobes).
- Handshakes with instruction and data memory, which may stall.
- Sits between the CPU top and the datapath sub-blocks, replacing the externally driven pc.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and on start.
PC_STEP, 1, PC increment per instruction (word addressing).
MAX_WAIT, 15, cycles a memory request may wait for ack before fault; 4-bit wait counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
start  in  1  pulse: leave IDLE/HALT, reload RESET_PC, begin fetching.
imem_req  out  1  instruction fetch request, held until imem_ack.
imem_addr  out  32  fetch address (= pc).
imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction.
ir  out  32  latched instruction to IDecode.
id_en  out  1  decode enable (one-cycle pulse).
is_load  in  1  decoder class flag, valid in DECODE.
is_store  in  1  decoder class flag, valid in DECODE.
is_branch  in  1  decoder class flag, valid in DECODE.
is_halt  in  1  decoder class flag, valid in DECODE.
branch_taken  in  1  ALU compare result, valid in EXEC.
branch_target  in  32  branch destination, valid in EXEC.
alu_en  out  1  ALU enable (one-cycle pulse in EXEC).
dmem_req  out  1  data memory request, held until dmem_ack.
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
dmem_ack  in  1  data access complete.
reg_we  out  1  register file write enable (one-cycle pulse in WB).
pc  out  32  current program counter.
busy  out  1  high in every state except IDLE and HALT.
halted  out  1  high in HALT.
fault  out  1  sticky: memory ack timeout occurred.
retired  out  32  count of completed instructions, wraps at 2^32.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; pc = RESET_PC; ir = 0; retired = 0; fault = 0.
  - All strobes and req outputs = 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start -> FETCH, pc <= RESET_PC.
- FETCH:
  - imem_req = 1.
  - On imem_ack: ir <= imem_rdata -> DECODE.
  - Otherwise wait_cnt++. When wait_cnt reaches MAX_WAIT without ack: fault <= 1 -> HALT.
- DECODE: id_en = 1.
  - is_halt -> HALT, no retire.
  - Otherwise -> EXEC.
  - Flag priority: halt > load/store > branch.
- EXEC: alu_en = 1.
  - Load/store -> MEM.
  - Branch -> WB, branch target latched if taken.
  - Else -> WB.
- MEM:
  - dmem_req = 1; dmem_we = is_store (latched in DECODE).
  - On dmem_ack -> WB.
  - Same timeout rule as FETCH.
- WB:
  - reg_we = 1 unless store or branch.
  - pc <= branch_taken_q ? branch_target_q : pc + PC_STEP (32-bit wrap).
  - retired++.
  - -> FETCH.
- HALT: holds pc, ir and retired. start -> FETCH with pc <= RESET_PC, fault cleared, retired kept.
- wait_cnt clears on every state entry.
- ack arriving in the same cycle as the timeout compare: ack wins, no fault.
- start is ignored while busy.
- Instruction latency, zero-wait memory:
  - ALU op: 4 cycles (F, D, E, W).
  - Load/store: 5 cycles.
- Reset mid-access: req drops immediately (async). The memory side must tolerate an abandoned request.
- Outputs are registered or decoded from state only; no combinational path from ack to req.

Decomposition:
- Shared package cpu_pkg:
  - state enum encoding (3 bits).
  - RESET_PC default.
  - instruction-class flag bit positions.
- Natural sub-module: mem_wait_timer. It holds the 4-bit wait counter, clear-on-entry and timeout compare. It is instantiated once, muxed between FETCH and MEM.

Test Plan:
- Reset then start, imem_ack same cycle, ALU op 32'h0000_0020 -> id_en at cycle 2, alu_en at 3, reg_we at 4; pc 0->1; retired = 1.
- Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we = 0, reg_we once; total 8 cycles.
- Store -> dmem_we = 1, reg_we never asserted; pc +1.
- Branch, taken = 1, target 32'h0000_0040 -> pc = 32'h40 after WB; with taken = 0 -> pc = old + 1.
- imem_ack withheld 15 cycles -> fault = 1, halted = 1, pc unchanged. Then start -> fault = 0, pc = 0.
- rst_n low mid-MEM -> dmem_req = 0 asynchronously, state IDLE, retired = 0; is_halt instruction -> halted, retired unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_pkg                                                    |
// | Description : Shared definitions for the multi-cycle CPU sequencer:      |
// |               3-bit state encoding, reset PC default and the bit         |
// |               positions of the decoder instruction-class flag vector.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cpu_pkg;

  // Sequencer state encoding (3 bits)
  typedef logic [2:0] state_t;

  localparam state_t c_st_idle   = 3'd0;
  localparam state_t c_st_fetch  = 3'd1;
  localparam state_t c_st_decode = 3'd2;
  localparam state_t c_st_exec   = 3'd3;
  localparam state_t c_st_mem    = 3'd4;
  localparam state_t c_st_wb     = 3'd5;
  localparam state_t c_st_halt   = 3'd6;

  // Default program counter after reset / start
  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  // Bit positions inside the instruction-class flag vector
  localparam int c_cls_load   = 0;
  localparam int c_cls_store  = 1;
  localparam int c_cls_branch = 2;
  localparam int c_cls_halt   = 3;
  localparam int c_cls_w      = 4;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_wait_timer                                             |
// | Description : 4-bit wait counter shared by the instruction and data      |
// |               memory handshakes. Counts cycles a request waits without   |
// |               an ack and flags a timeout on the last allowed cycle.      |
// | Ports       : clk, rst_n  - clock, async active-low reset                |
// |               clr         - clear counter (state is changing)            |
// |               active      - a memory request is outstanding              |
// |               ack         - ack of the memory currently being waited on  |
// |               timeout     - request has waited MAX_WAIT cycles, no ack   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic active,
  input  logic ack,
  output logic timeout
);

  // The counter holds the number of unacknowledged cycles already elapsed,
  // so the MAX_WAIT-th waiting cycle is the one where it equals MAX_WAIT-1.
  localparam logic [3:0] c_last = 4'(MAX_WAIT - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (clr) begin
      r_cnt <= 4'd0;
    end else if (active && !ack) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // An ack in the comparing cycle suppresses the timeout.
  assign timeout = active && !ack && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_sequencer                                              |
// | Description : Multi-cycle control unit. Owns the PC and sequences the    |
// |               datapath through FETCH/DECODE/EXEC/MEM/WB with stallable   |
// |               instruction and data memory handshakes.                    |
// | Ports       : clk, rst_n          - clock, async active-low reset        |
// |               start               - leave IDLE/HALT, restart at RESET_PC |
// |               imem_*              - instruction fetch handshake          |
// |               ir, id_en           - instruction and decode enable        |
// |               is_load/store/branch/halt - decoder class flags            |
// |               branch_taken/target - ALU branch result                    |
// |               alu_en              - ALU enable                           |
// |               dmem_req/we/ack     - data memory handshake                |
// |               reg_we              - register file write enable           |
// |               pc, busy, halted, fault, retired - status                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        id_en,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_halt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  state_t              r_state;
  state_t              w_state_next;

  logic [31:0]         r_pc;
  logic [31:0]         r_ir;
  logic [31:0]         r_retired;
  logic [31:0]         r_br_target;
  logic                r_fault;
  logic                r_is_mem;
  logic                r_is_store;
  logic                r_is_branch;
  logic                r_br_taken;

  logic [c_cls_w-1:0]  w_cls;
  logic                w_timer_active;
  logic                w_timer_ack;
  logic                w_timer_clr;
  logic                w_timeout;

  assign w_cls[c_cls_load]   = is_load;
  assign w_cls[c_cls_store]  = is_store;
  assign w_cls[c_cls_branch] = is_branch;
  assign w_cls[c_cls_halt]   = is_halt;

  // One timer serves both handshakes; only one of FETCH/MEM is ever active.
  assign w_timer_active = (r_state == c_st_fetch) || (r_state == c_st_mem);
  assign w_timer_ack    = (r_state == c_st_fetch) ? imem_ack : dmem_ack;
  // Clearing on every state change leaves the counter at zero on entry.
  assign w_timer_clr    = (w_state_next != r_state);

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_timer_clr),
    .active  (w_timer_active),
    .ack     (w_timer_ack),
    .timeout (w_timeout)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) w_state_next = c_st_fetch;
      end
      c_st_fetch: begin
        if (imem_ack)       w_state_next = c_st_decode;
        else if (w_timeout) w_state_next = c_st_halt;
      end
      c_st_decode: begin
        if (w_cls[c_cls_halt]) w_state_next = c_st_halt;
        else                   w_state_next = c_st_exec;
      end
      c_st_exec: begin
        if (r_is_mem) w_state_next = c_st_mem;
        else          w_state_next = c_st_wb;
      end
      c_st_mem: begin
        if (dmem_ack)       w_state_next = c_st_wb;
        else if (w_timeout) w_state_next = c_st_halt;
      end
      c_st_wb: begin
        w_state_next = c_st_fetch;
      end
      c_st_halt: begin
        if (start) w_state_next = c_st_fetch;
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Decoded from state and registered flags only, so no ack-to-req path.
  always_comb begin
    imem_req = 1'b0;
    id_en    = 1'b0;
    alu_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b1;
    halted   = 1'b0;
    case (r_state)
      c_st_idle:   busy = 1'b0;
      c_st_fetch:  imem_req = 1'b1;
      c_st_decode: id_en = 1'b1;
      c_st_exec:   alu_en = 1'b1;
      c_st_mem: begin
        dmem_req = 1'b1;
        dmem_we  = r_is_store;
      end
      c_st_wb:     reg_we = !(r_is_store || r_is_branch);
      c_st_halt: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default:     busy = 1'b0;
    endcase
  end

  // ----------------------------------------------------- pc / ir / status regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ir        <= 32'd0;
      r_retired   <= 32'd0;
      r_br_target <= 32'd0;
      r_fault     <= 1'b0;
      r_is_mem    <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_br_taken  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) r_pc <= RESET_PC;
        end
        c_st_fetch: begin
          if (imem_ack)       r_ir    <= imem_rdata;
          else if (w_timeout) r_fault <= 1'b1;
        end
        c_st_decode: begin
          // Load/store outranks branch; halt never reaches these flags.
          r_is_mem    <= w_cls[c_cls_load] || w_cls[c_cls_store];
          r_is_store  <= w_cls[c_cls_store];
          r_is_branch <= w_cls[c_cls_branch] &&
                         !(w_cls[c_cls_load] || w_cls[c_cls_store]);
        end
        c_st_exec: begin
          r_br_taken <= r_is_branch && branch_taken;
          if (r_is_branch && branch_taken) r_br_target <= branch_target;
        end
        c_st_mem: begin
          if (!dmem_ack && w_timeout) r_fault <= 1'b1;
        end
        c_st_wb: begin
          r_pc      <= r_br_taken ? r_br_target : (r_pc + PC_STEP);
          r_retired <= r_retired + 32'd1;
        end
        c_st_halt: begin
          if (start) begin
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign retired   = r_retired;
  assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_sequencer                                           |
// | Description : Directed self-checking bench for cpu_sequencer with        |
// |               hand-computed expected values per instruction.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] ir;
  logic        id_en;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        is_branch = 1'b0;
  logic        is_halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        reg_we;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-instruction observations
  int res_cycles, res_id_at, res_alu_at, res_we_at, res_alu, res_reg_we, res_dmem;
  int res_dmem_we, res_done;

  cpu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ir            (ir),
    .id_en         (id_en),
    .is_load       (is_load),
    .is_store      (is_store),
    .is_branch     (is_branch),
    .is_halt       (is_halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .alu_en        (alu_en),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .reg_we        (reg_we),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH until the next FETCH (or HALT), acting
  // as memory, decoder and ALU. cls = {halt, branch, store, load}.
  task automatic run_instr(input logic [31:0] instr, input logic [3:0] cls,
                           input logic taken, input logic [31:0] target,
                           input int iwait, input int dwait);
    int fw;
    int dw;
    bit seen_d;
    fw = 0; dw = 0; seen_d = 0;
    res_cycles = 0; res_id_at = 0; res_alu_at = 0; res_we_at = 0;
    res_alu = 0; res_reg_we = 0; res_dmem = 0; res_dmem_we = 0; res_done = 0;
    for (int i = 0; i < 64; i++) begin
      res_cycles++;
      imem_ack   = imem_req && (fw == iwait);
      imem_rdata = imem_ack ? instr : 32'hdead_beef;
      if (imem_req && !imem_ack) fw++;
      {is_halt, is_branch, is_store, is_load} = id_en ? cls : 4'b0000;
      branch_taken  = alu_en ? taken : 1'b0;
      branch_target = alu_en ? target : 32'hffff_ffff;
      dmem_ack = dmem_req && (dw == dwait);
      if (dmem_req && !dmem_ack) dw++;
      if (id_en) begin
        seen_d = 1;
        if (res_id_at == 0) res_id_at = res_cycles;
      end
      if (alu_en) begin res_alu++; res_alu_at = res_cycles; end
      if (reg_we) begin res_reg_we++; res_we_at = res_cycles; end
      if (dmem_req) begin
        res_dmem++;
        if (dmem_we) res_dmem_we = 1;
      end
      tick();
      if (halted || (seen_d && imem_req)) begin
        res_done = 1;
        break;
      end
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    {is_halt, is_branch, is_store, is_load} = 4'b0000;
    branch_taken = 1'b0;
    check_eq("instr_completes", 32'(res_done), 32'd1);
  endtask

  initial begin
    // ---------------------------------------------------------- reset state
    tick(); tick();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_ir", ir, 32'h0);
    check_eq("rst_retired", retired, 32'h0);
    check_eq("rst_strobes", {28'd0, imem_req, dmem_req, reg_we, busy}, 32'h0);
    check_eq("rst_fault_halted", {30'd0, fault, halted}, 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_no_start", 32'(busy), 32'd0);

    // ---------------------------------------------------- start, ALU op
    start = 1'b1; tick(); start = 1'b0;
    check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
    check_eq("fetch_addr", imem_addr, 32'h0);
    run_instr(32'h0000_0020, 4'b0000, 1'b0, 32'h0, 0, 0);
    check_eq("alu_cycles", 32'(res_cycles), 32'd4);
    check_eq("alu_id_at", 32'(res_id_at), 32'd2);
    check_eq("alu_alu_at", 32'(res_alu_at), 32'd3);
    check_eq("alu_we_at", 32'(res_we_at), 32'd4);
    check_eq("alu_ir", ir, 32'h0000_0020);
    check_eq("alu_pc", pc, 32'h1);
    check_eq("alu_retired", retired, 32'd1);

    // ---------------------------------------------- load, 3 wait cycles
    run_instr(32'h0000_1111, 4'b0001, 1'b0, 32'h0, 0, 3);
    check_eq("ld_cycles", 32'(res_cycles), 32'd8);
    check_eq("ld_dmem_cycles", 32'(res_dmem), 32'd4);
    check_eq("ld_dmem_we", 32'(res_dmem_we), 32'd0);
    check_eq("ld_reg_we", 32'(res_reg_we), 32'd1);
    check_eq("ld_pc", pc, 32'h2);

    // ------------------------------------------------------------- store
    run_instr(32'h0000_2222, 4'b0010, 1'b0, 32'h0, 0, 0);
    check_eq("st_cycles", 32'(res_cycles), 32'd5);
    check_eq("st_dmem_we", 32'(res_dmem_we), 32'd1);
    check_eq("st_reg_we", 32'(res_reg_we), 32'd0);
    check_eq("st_pc", pc, 32'h3);

    // ---------------------------------------------------------- branches
    run_instr(32'h0000_3333, 4'b0100, 1'b1, 32'h0000_0040, 0, 0);
    check_eq("br_t_cycles", 32'(res_cycles), 32'd4);
    check_eq("br_t_reg_we", 32'(res_reg_we), 32'd0);
    check_eq("br_t_pc", pc, 32'h40);
    run_instr(32'h0000_3334, 4'b0100, 1'b0, 32'h0000_0080, 0, 0);
    check_eq("br_nt_pc", pc, 32'h41);

    // load + branch flags together: load wins, branch ignored
    run_instr(32'h0000_4444, 4'b0101, 1'b1, 32'h0000_0080, 0, 0);
    check_eq("prio_cycles", 32'(res_cycles), 32'd5);
    check_eq("prio_reg_we", 32'(res_reg_we), 32'd1);
    check_eq("prio_pc", pc, 32'h42);
    check_eq("prio_retired", retired, 32'd6);

    // ------------------------------------------------ fetch timeout
    imem_ack = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check_eq("to_14_still_fetch", {30'd0, imem_req, fault}, 32'b10);
    tick();
    check_eq("to_halted", {30'd0, halted, fault}, 32'b11);
    check_eq("to_pc", pc, 32'h42);
    check_eq("to_busy_req", {30'd0, busy, imem_req}, 32'b00);
    check_eq("to_retired", retired, 32'd6);

    // ------------------------------------------- restart from HALT
    start = 1'b1; tick(); start = 1'b0;
    check_eq("restart_fault", 32'(fault), 32'd0);
    check_eq("restart_pc", pc, 32'h0);
    check_eq("restart_retired", retired, 32'd6);

    // ack in the very cycle the timeout would fire: ack wins
    run_instr(32'h0000_0021, 4'b0000, 1'b0, 32'h0, 14, 0);
    check_eq("ackwin_cycles", 32'(res_cycles), 32'd18);
    check_eq("ackwin_fault", {30'd0, fault, halted}, 32'b00);
    check_eq("ackwin_pc", pc, 32'h1);

    // ------------------------------ halt instruction (halt beats load)
    run_instr(32'hffff_0000, 4'b1001, 1'b0, 32'h0, 0, 0);
    check_eq("halt_cycles", 32'(res_cycles), 32'd2);
    check_eq("halt_halted", 32'(halted), 32'd1);
    check_eq("halt_alu", 32'(res_alu), 32'd0);
    check_eq("halt_retired", retired, 32'd7);
    check_eq("halt_pc", pc, 32'h1);

    // ---------------------------------------- async reset mid-MEM
    start = 1'b1; tick(); start = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0030; tick();
    imem_ack = 1'b0; is_load = 1'b1; tick();
    is_load = 1'b0; tick();
    check_eq("mid_mem_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_dmem_req", 32'(dmem_req), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_retired", retired, 32'd0);
    check_eq("async_ir", ir, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check_eq("post_rst_idle", {30'd0, busy, halted}, 32'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
